// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin N-master / M-slave bus: default
// parameter values, arbiter state encoding and an elaboration-time clog2.
package bus_pkg;

  localparam int unsigned DefNMasters = 4;
  localparam int unsigned DefNSlaves  = 4;
  localparam int unsigned DefAddrW    = 8;
  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefWinW     = 5;
  localparam int unsigned DefMaxHold  = 16;

  typedef enum logic {
    StPark  = 1'b0,
    StOwned = 1'b1
  } bus_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: ownership is held while the owner requests, then passes
// to the next requester after the owner. Optional hold limit: BUS_HOLD_LIMIT_EN.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = DefNMasters,
  parameter int unsigned MAX_HOLD  = DefMaxHold,
  localparam int unsigned IdxW     = (clog2(N_MASTERS) > 0) ? clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_MASTERS-1:0] req_i,
  output logic [IdxW-1:0]      owner_o,
  output logic [N_MASTERS-1:0] grant_o,
  output bus_state_e           state_o
);

  if (N_MASTERS < 2 || MAX_HOLD < 2) begin : g_bad_param
    $error("rr_arbiter: N_MASTERS and MAX_HOLD must be at least 2");
  end

  logic [IdxW-1:0]      owner_q, owner_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  bus_state_e           state;
  logic                 others_req;
  logic                 hold_expire;

  always_comb begin
    state      = req_i[owner_q] ? StOwned : StPark;
    others_req = |(req_i & ~grant_q);
  end

`ifdef BUS_HOLD_LIMIT_EN
  localparam int unsigned CntW = clog2(MAX_HOLD) + 1;

  logic [CntW-1:0] hold_q, hold_d;

  // Counts only contested cycles; expiry forces a handover on the next edge.
  always_comb begin
    hold_expire = (state == StOwned) && others_req && (hold_q >= CntW'(MAX_HOLD - 1));
    hold_d      = hold_q;
    if (owner_d != owner_q) begin
      hold_d = '0;
    end else if ((state == StOwned) && others_req) begin
      hold_d = hold_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  always_comb hold_expire = 1'b0;
`endif

  // Scan starts just after the owner, so the owner itself is considered last.
  always_comb begin
    logic            found;
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    owner_d  = owner_q;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if ((state == StPark) || hold_expire) begin
      for (int unsigned k = 1; k <= N_MASTERS; k++) begin
        cand     = (32'(owner_q) + k) % N_MASTERS;
        cand_idx = IdxW'(cand);
        if (!found && req_i[cand_idx]) begin
          owner_d = cand_idx;
          found   = 1'b1;
        end
      end
    end
    grant_d = N_MASTERS'(1) << owner_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= '0;
      grant_q <= N_MASTERS'(1);
    end else begin
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    owner_o = owner_q;
    grant_o = grant_q;
    state_o = state;
  end

endmodule

// File: rtl/bus_rr_nm.sv
// N-master / M-slave shared bus: round-robin ownership, windowed slave decode
// with out-of-range flag, and read data returned from the selected slave one cycle later.
// Optional hold limit on ownership: BUS_HOLD_LIMIT_EN.
module bus_rr_nm
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = DefNMasters,
  parameter int unsigned N_SLAVES  = DefNSlaves,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned WIN_W     = DefWinW,
  parameter int unsigned MAX_HOLD  = DefMaxHold
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_wr,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dout,
  input  logic [N_SLAVES*DATA_W-1:0]    s_dout,
  output logic [N_MASTERS-1:0]          m_grant,
  output logic [DATA_W-1:0]             m_din,
  output logic [N_SLAVES-1:0]           s_sel,
  output logic [ADDR_W-1:0]             s_address,
  output logic                          s_wr,
  output logic [DATA_W-1:0]             s_din,
  output logic                          s_err
);

  localparam int unsigned IdxW = (clog2(N_MASTERS) > 0) ? clog2(N_MASTERS) : 1;
  localparam int unsigned SelW = ADDR_W - WIN_W;
  localparam int unsigned SlvW = (clog2(N_SLAVES) > 0) ? clog2(N_SLAVES) : 1;

  if (N_SLAVES < 1 || N_SLAVES > 8 || WIN_W >= ADDR_W) begin : g_bad_param
    $error("bus_rr_nm: N_SLAVES must be 1..8 and WIN_W below ADDR_W");
  end

  logic [IdxW-1:0] owner;
  bus_state_e      state;
  logic            owner_req;
  logic [SelW-1:0] slv_idx;
  logic            in_range;
  logic            access_vld;

  logic [SlvW-1:0] rd_idx_q, rd_idx_d;
  logic            rd_vld_q, rd_vld_d;

  rr_arbiter #(
    .N_MASTERS (N_MASTERS),
    .MAX_HOLD  (MAX_HOLD)
  ) u_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (m_req),
    .owner_o (owner),
    .grant_o (m_grant),
    .state_o (state)
  );

  // Address forwards even while idle; everything else is gated by the owner's request.
  always_comb begin
    owner_req  = (state == StOwned);
    s_address  = m_address[owner*ADDR_W +: ADDR_W];
    slv_idx    = s_address[ADDR_W-1:WIN_W];
    in_range   = (32'(slv_idx) < N_SLAVES);
    access_vld = owner_req && in_range;
    s_sel      = access_vld ? (N_SLAVES'(1) << slv_idx) : '0;
    s_err      = owner_req && !in_range;
    s_wr       = m_wr[owner] && access_vld;
    s_din      = owner_req ? m_dout[owner*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    rd_vld_d = access_vld;
    rd_idx_d = access_vld ? SlvW'(slv_idx) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_idx_q <= rd_idx_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Slaves answer one cycle after selection, so pick their data with the registered index.
  always_comb begin
    m_din = rd_vld_q ? s_dout[rd_idx_q*DATA_W +: DATA_W] : '0;
  end

endmodule
